// File: rtl/proc_pkg.sv
// Shared definitions for the unidade_controle control unit: opcodes, ALU codes,
// instruction field positions, FSM states and the decoded control bundle.
package proc_pkg;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLi   = 6'h0F;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpJal  = 6'h03;
  localparam logic [5:0] OpPush = 6'h38;
  localparam logic [5:0] OpPop  = 6'h39;
  localparam logic [5:0] OpNop  = 6'h3F;

  localparam logic [3:0] AluAdd = 4'h2;
  localparam logic [3:0] AluSub = 4'h6;

  localparam int unsigned OpMsb    = 31;
  localparam int unsigned OpLsb    = 26;
  localparam int unsigned FunctMsb = 3;
  localparam int unsigned TgtMsb   = 25;
  localparam int unsigned RsLsb    = 20;
  localparam int unsigned RtMsb    = 19;
  localparam int unsigned RtLsb    = 14;
  localparam int unsigned RdMsb    = 13;
  localparam int unsigned RdLsb    = 8;
  localparam int unsigned ImmMsb   = 13;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       sum_zero;
    logic       ula_data;
    logic       jump;
    logic       link;
    logic       nop;
    logic       illegal;
    logic       branch;
    logic       branch_ne;
    logic       mem;
    logic       store;
    logic       stack;
  } ctrl_t;

  function automatic logic [31:0] sext_imm(input logic [ImmMsb:0] imm);
    return {{(31 - ImmMsb){imm[ImmMsb]}}, imm};
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Fetch/data handshakes and datapath control bundle between unidade_controle
// (master) and the register-bank/ALU datapath plus memories (slave).
interface unidade_controle_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        Zero;
  logic [5:0]  RS;
  logic [5:0]  RT;
  logic [5:0]  RD;
  logic [31:0] imediato;
  logic [3:0]  ALUOp;
  logic        ALUSrc;
  logic        SumZero;
  logic        ULAData;
  logic        RegWrite;
  logic        NOP;
  logic        StackOP;
  logic        JAL;
  logic        illegal;

  modport master (
    output imem_req, pc, dmem_req, dmem_we, RS, RT, RD, imediato, ALUOp, ALUSrc, SumZero,
           ULAData, RegWrite, NOP, StackOP, JAL, illegal,
    input  imem_ack, imem_data, dmem_ack, Zero
  );

  modport slave (
    input  imem_req, pc, dmem_req, dmem_we, RS, RT, RD, imediato, ALUOp, ALUSrc, SumZero,
           ULAData, RegWrite, NOP, StackOP, JAL, illegal,
    output imem_ack, imem_data, dmem_ack, Zero
  );
endinterface

// File: rtl/decodificador.sv
// Combinational opcode/funct decoder for unidade_controle. BNE is decoded only
// when UCTRL_BNE_EN is defined; otherwise opcode 6'h05 is flagged illegal.
module decodificador
  import proc_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [FunctMsb:0] funct,
  output ctrl_t             ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_op   = AluAdd;
    ctrl.ula_data = 1'b1;
    case (opcode)
      OpR:    ctrl.alu_op = funct;
      OpAddi: ctrl.alu_src = 1'b1;
      OpLi: begin
        // Zero + immediate: X comes from the forced zero operand, not dado1
        ctrl.alu_src  = 1'b1;
        ctrl.sum_zero = 1'b1;
        ctrl.ula_data = 1'b0;
      end
      OpLw: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem     = 1'b1;
      end
      OpSw: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem     = 1'b1;
        ctrl.store   = 1'b1;
      end
      OpBeq: begin
        ctrl.alu_op = AluSub;
        ctrl.branch = 1'b1;
      end
`ifdef UCTRL_BNE_EN
      OpBne: begin
        ctrl.alu_op    = AluSub;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
`endif
      OpJ:   ctrl.jump = 1'b1;
      OpJal: ctrl.link = 1'b1;
      OpPush: begin
        ctrl.mem   = 1'b1;
        ctrl.store = 1'b1;
        ctrl.stack = 1'b1;
      end
      OpPop: begin
        ctrl.mem   = 1'b1;
        ctrl.stack = 1'b1;
      end
      OpNop:   ctrl.nop = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch, decode and per-phase datapath control with PC
// ownership. Every output is a flop. UCTRL_BNE_EN enables BNE decoding.
module unidade_controle
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clock,
  input logic                reset_n,
  unidade_controle_if.master bus
);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [TgtMsb:0]   ir_q, ir_d;
  ctrl_t             ctrl_q, ctrl_d, dec_ctrl;
  logic              illegal_q, illegal_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              stack_op_q, stack_op_d;
  logic              reg_write_q, reg_write_d;
  logic              nop_q, nop_d;
  logic              jal_q, jal_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              alu_src_q, alu_src_d;
  logic              sum_zero_q, sum_zero_d;
  logic              ula_data_q, ula_data_d;
  logic              fetch_ack;
  logic [31:0]       imm32, pc_plus4;

  decodificador u_dec (
    .opcode (bus.imem_data[OpMsb:OpLsb]),
    .funct  (bus.imem_data[FunctMsb:0]),
    .ctrl   (dec_ctrl)
  );

  assign imm32     = sext_imm(ir_q[ImmMsb:0]);
  assign pc_plus4  = pc_q + 32'd4;
  assign fetch_ack = (state_q == StFetch) && imem_req_q && bus.imem_ack;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ctrl_d     = ctrl_q;
    illegal_d  = illegal_q;
    alu_op_d   = alu_op_q;
    alu_src_d  = alu_src_q;
    sum_zero_d = sum_zero_q;
    ula_data_d = ula_data_q;

    unique case (state_q)
      StFetch: begin
        if (fetch_ack) begin
          state_d   = StDecode;
          ir_d      = bus.imem_data[TgtMsb:0];
          ctrl_d    = dec_ctrl;
          illegal_d = illegal_q | dec_ctrl.illegal;
        end
      end
      StDecode: begin
        if (ctrl_q.jump || ctrl_q.link) begin
          pc_d    = {pc_q[31:28], ir_q, 2'b00};
          state_d = StFetch;
        end else if (ctrl_q.nop || ctrl_q.illegal) begin
          pc_d    = pc_plus4;
          state_d = StFetch;
        end else begin
          state_d    = StExec;
          alu_op_d   = ctrl_q.alu_op;
          alu_src_d  = ctrl_q.alu_src;
          sum_zero_d = ctrl_q.sum_zero;
          ula_data_d = ctrl_q.ula_data;
        end
      end
      StExec: begin
        if (ctrl_q.branch) begin
          // BEQ taken on Zero, BNE taken on !Zero
          if (bus.Zero ^ ctrl_q.branch_ne) begin
            pc_d = pc_plus4 + {imm32[29:0], 2'b00};
          end else begin
            pc_d = pc_plus4;
          end
          state_d = StFetch;
        end else if (ctrl_q.mem) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_req_q && bus.dmem_ack) begin
          if (ctrl_q.store) begin
            pc_d    = pc_plus4;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        pc_d    = pc_plus4;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Registered outputs reflect the state being entered; DECODE strobes use
    // the word being latched so they appear while pc still holds its address.
    imem_req_d  = (state_d == StFetch);
    dmem_req_d  = (state_d == StMem);
    dmem_we_d   = (state_d == StMem) && ctrl_q.store;
    stack_op_d  = ctrl_q.stack && ((state_d == StMem) || (state_d == StWb));
    jal_d       = fetch_ack && dec_ctrl.link;
    nop_d       = fetch_ack && (dec_ctrl.nop || dec_ctrl.illegal);
    reg_write_d = jal_d || ((state_q != StWb) && (state_d == StWb));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      stack_op_q  <= 1'b0;
      reg_write_q <= 1'b0;
      nop_q       <= 1'b0;
      jal_q       <= 1'b0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      sum_zero_q  <= 1'b0;
      ula_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      stack_op_q  <= stack_op_d;
      reg_write_q <= reg_write_d;
      nop_q       <= nop_d;
      jal_q       <= jal_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      sum_zero_q  <= sum_zero_d;
      ula_data_q  <= ula_data_d;
    end
  end

  assign bus.imem_req = imem_req_q;
  assign bus.pc       = pc_q;
  assign bus.dmem_req = dmem_req_q;
  assign bus.dmem_we  = dmem_we_q;
  assign bus.RS       = ir_q[TgtMsb:RsLsb];
  assign bus.RT       = ir_q[RtMsb:RtLsb];
  assign bus.RD       = ir_q[RdMsb:RdLsb];
  assign bus.imediato = imm32;
  assign bus.ALUOp    = alu_op_q;
  assign bus.ALUSrc   = alu_src_q;
  assign bus.SumZero  = sum_zero_q;
  assign bus.ULAData  = ula_data_q;
  assign bus.RegWrite = reg_write_q;
  assign bus.NOP      = nop_q;
  assign bus.StackOP  = stack_op_q;
  assign bus.JAL      = jal_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle (default build, BNE disabled).
module tb_unidade_controle;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_req;

  unidade_controle_if bus ();
  unidade_controle_if bus_hi ();

  unidade_controle #(.RESET_PC(32'h0000_0100)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  unidade_controle #(.RESET_PC(32'h8000_0000)) u_dut_hi (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_hi)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr);
    check_eq("imem_req_before_ack", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_data = instr;
    bus.imem_ack  = 1'b1;
    tick();
    bus.imem_ack  = 1'b0;
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [5:0] rs,
                                       input logic [5:0] rt, input logic [13:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  initial begin
    bus.imem_ack     = 1'b0;
    bus.imem_data    = '0;
    bus.dmem_ack     = 1'b0;
    bus.Zero         = 1'b0;
    bus_hi.imem_ack  = 1'b0;
    bus_hi.imem_data = '0;
    bus_hi.dmem_ack  = 1'b0;
    bus_hi.Zero      = 1'b0;

    repeat (2) tick();
    check_eq("rst_pc", bus.pc, 32'h100);
    check_eq("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    reset_n = 1'b1;
    tick();
    check_eq("rel_imem_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("rel_pc", bus.pc, 32'h100);
    check_eq("rel_strobes", {29'd0, bus.RegWrite, bus.NOP, bus.JAL}, 32'd0);
    check_eq("rel_dmem_req", {31'd0, bus.dmem_req}, 32'd0);

    // ADDI r3, r1, -4
    fetch(mk_i(6'h08, 6'd1, 6'd3, 14'h3FFC));
    check_eq("addi_rs", {26'd0, bus.RS}, 32'd1);
    check_eq("addi_rt", {26'd0, bus.RT}, 32'd3);
    check_eq("addi_imm", bus.imediato, 32'hFFFF_FFFC);
    tick();
    check_eq("addi_alusrc", {31'd0, bus.ALUSrc}, 32'd1);
    check_eq("addi_aluop", {28'd0, bus.ALUOp}, 32'h2);
    check_eq("addi_uladata", {31'd0, bus.ULAData}, 32'd1);
    check_eq("addi_exec_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    check_eq("addi_wb_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    check_eq("addi_wb_rt", {26'd0, bus.RT}, 32'd3);
    tick();
    check_eq("addi_regwrite_end", {31'd0, bus.RegWrite}, 32'd0);
    check_eq("addi_pc", bus.pc, 32'h104);

    // J 0x10 -> pc 0x40
    fetch(mk_j(6'h02, 26'h10));
    check_eq("j_strobes", {29'd0, bus.RegWrite, bus.NOP, bus.JAL}, 32'd0);
    tick();
    check_eq("j_pc", bus.pc, 32'h40);

    // BEQ imm=3 taken
    fetch(mk_i(6'h04, 6'd1, 6'd2, 14'd3));
    tick();
    check_eq("beq_aluop", {28'd0, bus.ALUOp}, 32'h6);
    check_eq("beq_alusrc", {31'd0, bus.ALUSrc}, 32'd0);
    bus.Zero = 1'b1;
    tick();
    bus.Zero = 1'b0;
    check_eq("beq_taken_pc", bus.pc, 32'h50);
    check_eq("beq_taken_regwrite", {31'd0, bus.RegWrite}, 32'd0);

    fetch(mk_j(6'h02, 26'h10));
    tick();
    check_eq("j2_pc", bus.pc, 32'h40);

    // BEQ imm=3 not taken
    fetch(mk_i(6'h04, 6'd1, 6'd2, 14'd3));
    tick();
    check_eq("beq_nt_exec_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    check_eq("beq_nt_pc", bus.pc, 32'h44);
    check_eq("beq_nt_regwrite", {31'd0, bus.RegWrite}, 32'd0);

    // LW with dmem_ack after 3 wait cycles
    fetch(mk_i(6'h23, 6'd1, 6'd4, 14'd8));
    tick();
    check_eq("lw_alusrc", {31'd0, bus.ALUSrc}, 32'd1);
    tick();
    check_eq("lw_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
    check_eq("lw_stackop", {31'd0, bus.StackOP}, 32'd0);
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dmem_req) n_req++;
      if (i == 3) bus.dmem_ack = 1'b1;
      tick();
    end
    bus.dmem_ack = 1'b0;
    check_eq("lw_req_cycles", n_req, 32'd4);
    check_eq("lw_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    check_eq("lw_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    tick();
    check_eq("lw_pc", bus.pc, 32'h48);
    check_eq("lw_regwrite_end", {31'd0, bus.RegWrite}, 32'd0);

    // JAL 0x10 on the high-PC instance
    bus_hi.imem_data = mk_j(6'h03, 26'h10);
    bus_hi.imem_ack  = 1'b1;
    tick();
    bus_hi.imem_ack  = 1'b0;
    check_eq("jal_pulse", {30'd0, bus_hi.JAL, bus_hi.RegWrite}, 32'd3);
    check_eq("jal_pc_link", bus_hi.pc, 32'h8000_0000);
    tick();
    check_eq("jal_pulse_end", {30'd0, bus_hi.JAL, bus_hi.RegWrite}, 32'd0);
    check_eq("jal_pc", bus_hi.pc, 32'h8000_0040);

    // Opcode 6'h05 is illegal without the BNE option
    fetch(mk_i(6'h05, 6'd1, 6'd2, 14'd1));
    check_eq("ill_flag", {31'd0, bus.illegal}, 32'd1);
    check_eq("ill_nop", {31'd0, bus.NOP}, 32'd1);
    tick();
    check_eq("ill_pc", bus.pc, 32'h4C);
    check_eq("ill_sticky", {31'd0, bus.illegal}, 32'd1);
    check_eq("ill_nop_end", {31'd0, bus.NOP}, 32'd0);

    // SW aborted by reset in MEM
    fetch(mk_i(6'h2B, 6'd1, 6'd5, 14'd0));
    tick();
    tick();
    check_eq("sw_dmem_req", {31'd0, bus.dmem_req}, 32'd1);
    check_eq("sw_dmem_we", {31'd0, bus.dmem_we}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("abort_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    check_eq("abort_illegal", {31'd0, bus.illegal}, 32'd0);
    check_eq("abort_pc", bus.pc, 32'h100);
    check_eq("abort_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rerel_imem_req", {31'd0, bus.imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
